uc_alu: RTL and testbench

UC_ALU -- requirements
Module: uc_alu

---
 rtl/uc_pkg.sv | 27 ++
 rtl/alu_core.sv | 51 +++++
 rtl/uc_alu.sv | 137 +++++++++++++
 tb/tb_uc_alu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared constants for the micro-controller ALU: function codes, write-back bit, FSM states.
package uc_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int WB_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } uc_state_t;

    function automatic logic code_valid(input logic [3:0] code);
        return code <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU for function codes 0-7 with carry/borrow out.
module alu_core
    import uc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       code,
    output logic [WIDTH-1:0] y,
    output logic             cy
);

    logic [WIDTH:0] ext;

    always_comb begin
        y   = '0;
        cy  = 1'b0;
        ext = '0;
        case (code)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                y   = ext[WIDTH-1:0];
                cy  = ext[WIDTH];
            end
            // Top bit of the widened difference is the borrow (A < B).
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                y   = ext[WIDTH-1:0];
                cy  = ext[WIDTH];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y  = {a[WIDTH-2:0], 1'b0};
                cy = a[WIDTH-1];
            end
            OP_SHR: begin
                y  = {1'b0, a[WIDTH-1:1]};
                cy = a[0];
            end
            default: begin
                y  = '0;
                cy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uc_alu.sv
// Multi-cycle ALU: latches an instruction on start, executes (shift-add for MUL),
// and registers result, flags and the register-A write-back strobe.
module uc_alu
    import uc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    input  logic [7:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] tempRegA,
    output logic             flagUC,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    uc_state_t          state;
    logic               exec_phase;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [3:0]         code_q;
    logic               wb_q;
    logic [WIDTH-1:0]   stage_y;
    logic               stage_cy;
    logic [2*WIDTH-1:0] acc, mcand, acc_step;
    logic [WIDTH-1:0]   mplier;
    logic [3:0]         cnt;

    logic [WIDTH-1:0]   alu_y, fin_y;
    logic               alu_cy, fin_cy, to_wb, mul_last;
    logic               unused_opcode_bits;

    assign unused_opcode_bits = ^opcode[6:4];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a    (a_q),
        .b    (b_q),
        .code (code_q),
        .y    (alu_y),
        .cy   (alu_cy)
    );

    assign busy     = (state != IDLE);
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (state == MUL) && (cnt == 4'(MUL_CYCLES - 1));
    assign to_wb    = ((state == EXEC) && exec_phase && (code_q != OP_MUL)) || mul_last;
    assign fin_y    = (state == MUL) ? acc_step[WIDTH-1:0] : stage_y;
    assign fin_cy   = (state == MUL) ? (|acc_step[2*WIDTH-1:WIDTH]) : stage_cy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            exec_phase <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            code_q     <= '0;
            wb_q       <= 1'b0;
            stage_y    <= '0;
            stage_cy   <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            result     <= '0;
            tempRegA   <= '0;
            flagUC     <= 1'b0;
            done       <= 1'b0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done   <= 1'b0;
            flagUC <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q        <= regA;
                        b_q        <= regB;
                        code_q     <= opcode[3:0];
                        wb_q       <= opcode[WB_BIT];
                        exec_phase <= 1'b0;
                        state      <= EXEC;
                    end
                end
                // EXEC spans two cycles: the first registers the alu_core outputs and
                // primes the multiplier, the second dispatches to MUL or WB.
                EXEC: begin
                    if (!exec_phase) begin
                        stage_y    <= alu_y;
                        stage_cy   <= alu_cy;
                        acc        <= '0;
                        mcand      <= {{WIDTH{1'b0}}, a_q};
                        mplier     <= b_q;
                        cnt        <= '0;
                        exec_phase <= 1'b1;
                    end else begin
                        state <= (code_q == OP_MUL) ? MUL : WB;
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                    if (mul_last)
                        state <= WB;
                end
                WB: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (to_wb) begin
                done <= 1'b1;
                if (code_valid(code_q)) begin
                    result <= fin_y;
                    carry  <= fin_cy;
                    zero   <= (fin_y == '0);
                    err    <= 1'b0;
                    if (wb_q) begin
                        tempRegA <= fin_y;
                        flagUC   <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uc_alu.sv
// Directed self-checking bench for uc_alu with hand-computed expectations.
module tb_uc_alu;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] regA = '0, regB = '0, opcode = '0;
    logic [7:0] result, tempRegA;
    logic       flagUC, busy, done, carry, zero, err;

    int total = 0;
    int bad   = 0;
    int n;
    logic pulse_seen;

    uc_alu #(.WIDTH(8), .MUL_CYCLES(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .regA     (regA),
        .regB     (regB),
        .opcode   (opcode),
        .result   (result),
        .tempRegA (tempRegA),
        .flagUC   (flagUC),
        .busy     (busy),
        .done     (done),
        .carry    (carry),
        .zero     (zero),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        regA   = a;
        regB   = b;
        opcode = op;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        regA   = ~a;
        regB   = ~b;
        opcode = 8'h00;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done && cnt < 40);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_tempRegA", tempRegA, 0);
        chk("rst_flagUC", flagUC, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_err", err, 0);

        // ADD with write-back
        issue(8'h7F, 8'h01, 8'h80);
        chk("add_busy", busy, 1);
        wait_done(n);
        chk("add_lat", n, 2);
        chk("add_result", result, 8'h80);
        chk("add_carry", carry, 0);
        chk("add_zero", zero, 0);
        chk("add_tempRegA", tempRegA, 8'h80);
        chk("add_flagUC", flagUC, 1);
        tick();
        chk("add_done_fall", done, 0);
        chk("add_flagUC_fall", flagUC, 0);
        chk("add_busy_fall", busy, 0);

        // SUB with borrow, no write-back
        issue(8'h05, 8'h07, 8'h01);
        wait_done(n);
        chk("sub_lat", n, 2);
        chk("sub_result", result, 8'hFE);
        chk("sub_carry", carry, 1);
        chk("sub_flagUC", flagUC, 0);
        chk("sub_tempRegA", tempRegA, 8'h80);
        tick();

        // MUL with write-back and an ignored start mid-multiply
        issue(8'h10, 8'h11, 8'h88);
        tick();
        tick();
        tick();
        regA   = 8'h01;
        regB   = 8'h01;
        opcode = 8'h80;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(n);
        chk("mul_lat", n, 6);
        chk("mul_result", result, 8'h10);
        chk("mul_carry", carry, 1);
        chk("mul_tempRegA", tempRegA, 8'h10);
        chk("mul_flagUC", flagUC, 1);
        pulse_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) pulse_seen = 1'b1;
        end
        chk("mul_start_not_queued", pulse_seen, 0);

        // ADD without write-back, then an invalid code
        issue(8'h7F, 8'h01, 8'h00);
        wait_done(n);
        chk("add2_result", result, 8'h80);
        chk("add2_flagUC", flagUC, 0);
        chk("add2_tempRegA", tempRegA, 8'h10);
        tick();
        issue(8'h12, 8'h34, 8'h8C);
        wait_done(n);
        chk("inv_lat", n, 2);
        chk("inv_err", err, 1);
        chk("inv_result", result, 8'h80);
        chk("inv_carry", carry, 0);
        chk("inv_zero", zero, 0);
        chk("inv_flagUC", flagUC, 0);
        chk("inv_tempRegA", tempRegA, 8'h10);
        tick();
        chk("inv_done_once", done, 0);

        // SHR to zero; clears err
        issue(8'h01, 8'h00, 8'h07);
        wait_done(n);
        chk("shr_result", result, 8'h00);
        chk("shr_zero", zero, 1);
        chk("shr_carry", carry, 1);
        chk("shr_err", err, 0);
        tick();

        issue(8'h81, 8'h00, 8'h86);
        wait_done(n);
        chk("shl_result", result, 8'h02);
        chk("shl_carry", carry, 1);
        chk("shl_tempRegA", tempRegA, 8'h02);
        tick();

        issue(8'hF0, 8'hFF, 8'h04);
        wait_done(n);
        chk("xor_result", result, 8'h0F);
        chk("xor_carry", carry, 0);
        tick();

        issue(8'h55, 8'h00, 8'h05);
        wait_done(n);
        chk("not_result", result, 8'hAA);
        tick();

        // reset wins over start on the same edge
        regA   = 8'h01;
        regB   = 8'h01;
        opcode = 8'h80;
        start  = 1'b1;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("prio_busy", busy, 0);
        chk("prio_result", result, 0);
        tick();
        chk("prio_busy2", busy, 0);

        // reset during the 4th MUL cycle
        issue(8'h03, 8'h05, 8'h88);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_tempRegA", tempRegA, 0);
        chk("abort_flags", {carry, zero, err, done, flagUC}, 0);
        pulse_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done || flagUC) pulse_seen = 1'b1;
        end
        chk("abort_no_pulse", pulse_seen, 0);

        issue(8'h01, 8'h02, 8'h80);
        wait_done(n);
        chk("post_lat", n, 2);
        chk("post_result", result, 8'h03);
        chk("post_tempRegA", tempRegA, 8'h03);
        chk("post_flagUC", flagUC, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
